data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameters SHALL be:
- DEPTH_WORDS, default 256, word count of backing store (power of two).
- WAIT_STATES, default 1, extra cycles between accept and response (0..15).

REQ-002 Ports SHALL be:
- clk  in  1  clock; single clock domain, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  responder accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  1 = zero-extend load, 0 = sign-extend.
- rsp_valid  out  1  response present.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  request faulted.
- rsp_ready  in  1  core consumes the response.

Function
REQ-003 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-004 Handshake: a request SHALL be accepted when req_valid and req_ready are both 1; all request fields SHALL be latched at that edge.
REQ-005 After accept, the FSM SHALL go to WAIT if WAIT_STATES > 0, else directly to RESP.
REQ-006 WAIT SHALL count exactly WAIT_STATES cycles, then enter RESP.
- Accept-to-rsp_valid latency SHALL be WAIT_STATES+1 cycles.
REQ-007 In RESP, rsp_valid SHALL be 1 and rsp_rdata and rsp_err SHALL be held stable until rsp_ready is 1.
- On rsp_valid and rsp_ready, the FSM SHALL return to IDLE.
- A new request SHALL be acceptable in the following cycle, never the same one.
REQ-008 Word index SHALL be req_addr[2 +: log2(DEPTH_WORDS)]; byte lane SHALL be req_addr[1:0].
REQ-009 Error SHALL be flagged, with no memory update and rsp_rdata = 0, when any of these hold:
- req_size = 11;
- half access with addr[0] = 1;
- word access with addr[1:0] != 00;
- req_addr >= DEPTH_WORDS*4.
REQ-010 A load SHALL extract the addressed byte, half or word and extend it to 32 bits per req_unsigned; a word load SHALL ignore req_unsigned.
REQ-011 A store SHALL write only the addressed lanes.
- Byte: one byte enable from req_wdata[7:0].
- Half: two enables from req_wdata[15:0].
- Word: all four enables.
- Unaddressed bytes SHALL be preserved.
REQ-012 A store SHALL commit on the clock edge that enters RESP, exactly once per request.
REQ-013 A load SHALL read the store contents as they are on the edge entering RESP, so it observes all previously committed stores.

Reset
REQ-014 While reset = 0 at a rising edge:
- FSM SHALL go to IDLE and the wait counter to 0;
- req_ready SHALL be 1 after release; rsp_valid, rsp_err and rsp_rdata SHALL be 0.
REQ-015 Reset asserted in WAIT or RESP SHALL abandon the request.
- An uncommitted store SHALL not be written.
- No response SHALL be issued for the abandoned request.
REQ-016 Backing store contents SHALL not be affected by reset.

Structure
REQ-017 A shared package mem_pkg SHALL hold:
- size encodings SIZE_B, SIZE_H, SIZE_W;
- the FSM state type;
- the WAIT_STATES counter width constant.
REQ-018 Lane logic SHALL live in one combinational sub-module, mem_lane_align. It SHALL take size, lane, unsigned flag, store data and read word, and SHALL produce byte enables, aligned write data and the extended load value.

Verification
REQ-019 Store word then load word:
- Store 0xDEADBEEF to 0x10, then load word 0x10 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- With WAIT_STATES = 1, rsp_valid SHALL rise 2 cycles after each accept.
REQ-020 Byte lane and extension:
- Store byte 0x80 to 0x13 over word 0x00000000.
- Load word 0x10 -> 0x80000000.
- Signed byte load 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-021 Misalignment faults:
- Load half at 0x21 -> rsp_err = 1, rsp_rdata = 0.
- Store word at 0x22 -> rsp_err = 1 and word 0x20 unchanged.
REQ-022 Backpressure: hold rsp_ready = 0 for 5 cycles during a load.
- rsp_valid and rsp_rdata SHALL stay stable and req_ready SHALL stay 0.
- Release rsp_ready -> response completes and the FSM returns to IDLE next cycle.
REQ-023 Reset mid-store: assert reset in WAIT during a store of 0x12345678 to 0x40.
- Word 0x40 SHALL keep its old value.
- No response SHALL be issued and req_ready = 1 after release.
REQ-024 Out of range: load at DEPTH_WORDS*4 (0x400 for the default) -> rsp_err = 1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory responder.
package mem_pkg;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_ILL = 2'b11;

    localparam int WCNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_al,
    output logic [31:0] load_val
);

    logic [31:0] shifted;

    always_comb begin
        be       = '0;
        wdata_al = '0;
        load_val = '0;
        shifted  = rword >> {lane, 3'b000};
        unique case (size)
            SIZE_B: begin
                be       = 4'b0001 << lane;
                wdata_al = {4{wdata[7:0]}};
                load_val = is_unsigned ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{wdata[15:0]}};
                load_val = is_unsigned ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            end
            SIZE_W: begin
                be       = 4'b1111;
                wdata_al = wdata;
                load_val = rword;
            end
            default: begin
                be = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory with configurable wait states and
// valid/ready request and response channels.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        rsp_ready
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [WCNT_W-1:0] LAST =
        WCNT_W'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    state_t state_q, state_d;
    logic [WCNT_W-1:0] cnt_q;
    logic enter_resp;

    logic        lat_we, lat_uns;
    logic [31:0] lat_addr, lat_wdata;
    logic [1:0]  lat_size;

    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    // With zero wait states RESP is entered on the accept edge itself,
    // so the live request fields stand in for the latched ones in IDLE.
    logic        cur_we, cur_uns, cur_err;
    logic [31:0] cur_addr, cur_wdata;
    logic [1:0]  cur_size;
    logic [AW-1:0] cur_idx;

    assign cur_we    = (state_q == IDLE) ? req_we       : lat_we;
    assign cur_uns   = (state_q == IDLE) ? req_unsigned : lat_uns;
    assign cur_addr  = (state_q == IDLE) ? req_addr     : lat_addr;
    assign cur_wdata = (state_q == IDLE) ? req_wdata    : lat_wdata;
    assign cur_size  = (state_q == IDLE) ? req_size     : lat_size;
    assign cur_idx   = cur_addr[2 +: AW];

    assign cur_err = (cur_size == SIZE_ILL)
                   | ((cur_size == SIZE_H) & cur_addr[0])
                   | ((cur_size == SIZE_W) & (cur_addr[1:0] != 2'b00))
                   | (|cur_addr[31:AW+2]);

    logic [3:0]  be;
    logic [31:0] wdata_al, load_val, rword;

    assign rword = mem[cur_idx];

    mem_lane_align u_lane (
        .size        (cur_size),
        .lane        (cur_addr[1:0]),
        .is_unsigned (cur_uns),
        .wdata       (cur_wdata),
        .rword       (rword),
        .be          (be),
        .wdata_al    (wdata_al),
        .load_val    (load_val)
    );

    always_comb begin
        state_d    = state_q;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == LAST) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_size  <= SIZE_B;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                lat_we    <= req_we;
                lat_uns   <= req_unsigned;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_size  <= req_size;
                cnt_q     <= '0;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (enter_resp) begin
                err_q   <= cur_err;
                rdata_q <= (cur_err || cur_we) ? 32'h0 : load_val;
            end
        end
    end

    // Store contents survive reset; a store held in reset never commits.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && cur_we && !cur_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[cur_idx][b*8 +: 8] <= wdata_al[b*8 +: 8];
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
    assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed table, hand sequences and random traffic
// against a byte-addressed reference memory.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int WS    = 1;
    localparam int BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_ready = 1'b1;

    int checks = 0;
    int failures = 0;

    logic [7:0] rb [BYTES];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .rsp_ready    (rsp_ready)
    );

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Reference: byte array, little-endian, fault rules from access size.
    task automatic model(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size,
                         input logic uns, output logic [31:0] rd,
                         output logic err);
        int n;
        longint unsigned val;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || ((addr % n) != 0) || (addr >= BYTES);
        rd = '0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) rb[addr + i] = wdata[8*i +: 8];
            end else begin
                val = 0;
                for (int i = 0; i < n; i++)
                    val = val + (longint'(rb[addr + i]) << (8 * i));
                if (n < 4 && !uns && val >= (64'd1 << (8 * n - 1)))
                    val = val + 64'hFFFF_FFFF - ((64'd1 << (8 * n)) - 1);
                rd = val[31:0];
            end
        end
    endtask

    task automatic txn(input string nm, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       input int hold, input logic use_exp,
                       input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] mrd, erd;
        logic merr, eerr;
        int k;
        model(we, addr, wdata, size, uns, mrd, merr);
        erd  = use_exp ? exp_rd : mrd;
        eerr = use_exp ? exp_err : merr;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        rsp_ready    = (hold == 0);
        check({nm, " req_ready_idle"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = $urandom_range(0, 1);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_size     = 2'($urandom_range(0, 3));
        req_unsigned = $urandom_range(0, 1);
        k = 1;
        @(negedge clk);
        while (!rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({nm, " latency"}, k, WS + 1);
        check({nm, " req_ready_busy"}, {31'b0, req_ready}, 32'd0);
        check({nm, " rdata"}, rsp_rdata, erd);
        check({nm, " err"}, {31'b0, rsp_err}, {31'b0, eerr});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({nm, " hold_valid"}, {31'b0, rsp_valid}, 32'd1);
            check({nm, " hold_rdata"}, rsp_rdata, erd);
            check({nm, " hold_ready"}, {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check({nm, " done_valid"}, {31'b0, rsp_valid}, 32'd0);
        check({nm, " done_ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    typedef struct {
        string       nm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t vec [15];

    initial begin
        vec[0]  = '{"st_w_10",   1'b1, 32'h10,  32'hDEADBEEF, 2'd2, 1'b0, 32'h0,        1'b0};
        vec[1]  = '{"ld_w_10",   1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0};
        vec[2]  = '{"clr_w_10",  1'b1, 32'h10,  32'h0,        2'd2, 1'b0, 32'h0,        1'b0};
        vec[3]  = '{"st_b_13",   1'b1, 32'h13,  32'hAAAA_AA80, 2'd0, 1'b0, 32'h0,       1'b0};
        vec[4]  = '{"ld_w_10b",  1'b0, 32'h10,  32'h0,        2'd2, 1'b1, 32'h80000000, 1'b0};
        vec[5]  = '{"ld_bs_13",  1'b0, 32'h13,  32'h0,        2'd0, 1'b0, 32'hFFFFFF80, 1'b0};
        vec[6]  = '{"ld_bu_13",  1'b0, 32'h13,  32'h0,        2'd0, 1'b1, 32'h00000080, 1'b0};
        vec[7]  = '{"st_w_20",   1'b1, 32'h20,  32'h11223344, 2'd2, 1'b0, 32'h0,        1'b0};
        vec[8]  = '{"ld_h_21",   1'b0, 32'h21,  32'h0,        2'd1, 1'b0, 32'h0,        1'b1};
        vec[9]  = '{"st_w_22",   1'b1, 32'h22,  32'hAABBCCDD, 2'd2, 1'b0, 32'h0,        1'b1};
        vec[10] = '{"ld_w_20",   1'b0, 32'h20,  32'h0,        2'd2, 1'b0, 32'h11223344, 1'b0};
        vec[11] = '{"ld_w_400",  1'b0, 32'h400, 32'h0,        2'd2, 1'b0, 32'h0,        1'b1};
        vec[12] = '{"ld_ill_30", 1'b0, 32'h30,  32'h0,        2'd3, 1'b0, 32'h0,        1'b1};
        vec[13] = '{"ld_hu_22",  1'b0, 32'h22,  32'h0,        2'd1, 1'b1, 32'h00001122, 1'b0};
        vec[14] = '{"ld_hs_12",  1'b0, 32'h12,  32'h0,        2'd1, 1'b0, 32'hFFFF8000, 1'b0};

        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst req_ready", {31'b0, req_ready}, 32'd1);
        check("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst rsp_err",   {31'b0, rsp_err},   32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'h0);

        for (int w = 0; w < DEPTH; w++)
            txn("init", 1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0, 0,
                1'b0, 32'h0, 1'b0);

        foreach (vec[i])
            txn(vec[i].nm, vec[i].we, vec[i].addr, vec[i].wdata,
                vec[i].size, vec[i].uns, 0, 1'b1, vec[i].rd, vec[i].err);

        txn("bp_ld_w_10", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 5,
            1'b1, 32'h80000000, 1'b0);

        txn("st_w_40", 1'b1, 32'h40, 32'hCAFEF00D, 2'd2, 1'b0, 0,
            1'b1, 32'h0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'h12345678;
        req_size  = 2'd2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("midrst wait_valid", {31'b0, rsp_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midrst req_ready", {31'b0, req_ready}, 32'd1);
        check("midrst rdata", rsp_rdata, 32'h0);
        begin
            int seen = 0;
            repeat (5) begin
                @(negedge clk);
                if (rsp_valid) seen++;
            end
            check("midrst no_rsp", seen, 0);
        end
        txn("ld_w_40", 1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 0,
            1'b1, 32'hCAFEF00D, 1'b0);

        for (int t = 0; t < 400; t++) begin
            logic [31:0] a;
            logic [1:0] sz;
            a  = 32'($urandom_range(0, BYTES + 15));
            if ($urandom_range(0, 19) == 0) a = $urandom;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3
                                             : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            txn("rand", 1'($urandom_range(0, 1)), a, $urandom, sz,
                1'($urandom_range(0, 1)), $urandom_range(0, 2),
                1'b0, 32'h0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
